// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one outstanding
// req/gnt/rvalid transaction at a time, and buffers one instruction for ID.
// A redirect (flush) retargets the PC and squashes any wrong-path response.
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] next_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
  logic [DATA_W-1:0] inst_reg, inst_next;
  logic              inst_valid_reg, inst_valid_next;
  logic              discard_reg, discard_next;
  logic              req;

  // Only request when the output buffer is empty or drains this cycle, so a
  // response can never land on a full, stalled buffer.
  assign req = (state_reg == REQ) && (!inst_valid_reg || !stall_i);

  assign pc_o         = pc_reg;
  assign imem_req_o   = req;
  assign imem_addr_o  = pc_reg;
  assign inst_valid_o = inst_valid_reg;
  assign inst_o       = inst_reg;
  assign inst_pc_o    = inst_pc_reg;

  // Next-state, PC and output-buffer update; flush overrides everything last.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    inst_valid_next = inst_valid_reg;
    discard_next    = discard_reg;

    // ID takes the buffered instruction; a refill below may overwrite this.
    if (inst_valid_reg && !stall_i) begin
      inst_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (req && imem_gnt_i) begin
          state_next   = WAIT;
          // A grant coinciding with flush belongs to the old address.
          discard_next = flush_i;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_next   = REQ;
          discard_next = 1'b0;
          if (!discard_reg && !flush_i) begin
            inst_next       = imem_rdata_i;
            inst_pc_next    = pc_reg;
            inst_valid_next = 1'b1;
            pc_next         = next_addr_i;
          end
        end else if (flush_i) begin
          discard_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush_i) begin
      pc_next         = next_addr_i;
      inst_valid_next = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
      discard_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_valid_reg <= inst_valid_next;
      discard_reg    <= discard_next;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected request addresses
// and expected instructions; a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_addr_i;
  logic [31:0] pc_o;
  logic        flush_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  logic [31:0] flush_target;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] req_q[$];
  logic [63:0] inst_q[$];

  fetch_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_addr_i   (next_addr_i),
    .pc_o          (pc_o),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  always #5 clk = ~clk;

  // Next-address selector model: sequential pc+4 unless redirecting.
  assign next_addr_i = flush_i ? flush_target : pc_o + 32'd4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: request handshakes and instructions consumed by ID.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_o && imem_gnt_i) begin
        if (req_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: got addr %h, expected none", imem_addr_o);
        end else begin
          logic [31:0] ea;
          ea = req_q.pop_front();
          check("req_addr", imem_addr_o, ea);
          $display("req  addr=%h expected=%h", imem_addr_o, ea);
        end
      end
      if (inst_valid_o && !stall_i && !flush_i) begin
        if (inst_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_inst: got %h@%h, expected none", inst_o, inst_pc_o);
        end else begin
          logic [63:0] ei;
          ei = inst_q.pop_front();
          check("inst", inst_o, ei[63:32]);
          check("inst_pc", inst_pc_o, ei[31:0]);
          $display("inst %h@%h expected %h@%h", inst_o, inst_pc_o, ei[63:32], ei[31:0]);
        end
      end
    end
  end

  // Wait (bounded) for a request and check its address.
  task automatic wait_req(input logic [31:0] addr);
    int n;
    n = 0;
    while (!imem_req_o && n < 20) begin
      tick();
      n++;
    end
    check("req_present", 32'(imem_req_o), 32'd1);
    check("req_addr_now", imem_addr_o, addr);
  endtask

  // One full transaction: optional grant delay, gnt, rvalid one cycle later.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int gnt_wait);
    wait_req(addr);
    for (int i = 0; i < gnt_wait; i++) begin
      check("req_hold", 32'(imem_req_o), 32'd1);
      check("addr_hold", imem_addr_o, addr);
      tick();
    end
    check("req_before_gnt", 32'(imem_req_o), 32'd1);
    imem_gnt_i = 1'b1;
    req_q.push_back(addr);
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    inst_q.push_back({data, addr});
    tick();
    imem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0; flush_target = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    repeat (3) tick();
    check("rst_pc", pc_o, 32'h0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_inst_pc", inst_pc_o, 32'h0);
    rst_n = 1'b1;
    check("idle_req", 32'(imem_req_o), 32'd0);
    tick();

    // Basic fetch, then a grant held off for three cycles.
    fetch(32'h0, 32'h1111, 0);
    check("first_valid", 32'(inst_valid_o), 32'd1);
    check("first_inst", inst_o, 32'h1111);
    check("first_pc", inst_pc_o, 32'h0);
    fetch(32'h4, 32'h2222, 3);

    // Stall with a full buffer: no request, outputs held.
    wait_req(32'h8);
    imem_gnt_i = 1'b1;
    req_q.push_back(32'h8);
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333; stall_i = 1'b1;
    inst_q.push_back({32'h3333, 32'h8});
    tick();
    imem_rvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_req", 32'(imem_req_o), 32'd0);
      check("stall_inst", inst_o, 32'h3333);
      check("stall_pc", inst_pc_o, 32'h8);
      check("stall_valid", 32'(inst_valid_o), 32'd1);
      tick();
    end
    stall_i = 1'b0;
    #1;
    check("resume_req", 32'(imem_req_o), 32'd1);
    imem_gnt_i = 1'b1;
    req_q.push_back(32'hC);
    tick();
    imem_gnt_i = 1'b0;

    // Flush while waiting on 0xC; the late 0xDEAD response is dropped.
    flush_i = 1'b1; flush_target = 32'h100;
    tick();
    flush_i = 1'b0;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD;
    tick();
    imem_rvalid_i = 1'b0;
    check("drop_valid", 32'(inst_valid_o), 32'd0);
    fetch(32'h100, 32'h4444, 0);

    // Flush coincident with grant: that response is dropped.
    tick();
    flush_i = 1'b1; flush_target = 32'h200; imem_gnt_i = 1'b1;
    req_q.push_back(32'h104);
    tick();
    flush_i = 1'b0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0;
    tick();
    imem_rvalid_i = 1'b0;
    check("gntflush_valid", 32'(inst_valid_o), 32'd0);
    fetch(32'h200, 32'h5555, 1);

    // Reset during WAIT, then a stray response in IDLE and REQ.
    tick();
    wait_req(32'h204);
    imem_gnt_i = 1'b1;
    req_q.push_back(32'h204);
    tick();
    imem_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_req", 32'(imem_req_o), 32'd0);
    check("arst_valid", 32'(inst_valid_o), 32'd0);
    check("arst_inst", inst_o, 32'h0);
    check("arst_inst_pc", inst_pc_o, 32'h0);
    tick();
    rst_n = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBEEF;
    tick();
    check("post_rst_req", 32'(imem_req_o), 32'd1);
    check("post_rst_addr", imem_addr_o, 32'h0);
    tick();
    imem_rvalid_i = 1'b0;
    check("stray_valid", 32'(inst_valid_o), 32'd0);
    fetch(32'h0, 32'h6666, 0);

    // Flush in REQ without grant, to the top of the address space; PC wraps.
    tick();
    flush_i = 1'b1; flush_target = 32'hFFFF_FFFC;
    tick();
    flush_i = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h7777, 0);
    check("wrap_addr", imem_addr_o, 32'h0);

    repeat (3) tick();
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    check("inst_q_empty", 32'(inst_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
